uart_rx_core: RTL and testbench

- UART receive engine: deserialises the asynchronous rx line into bytes and pushes each good frame into the Upstream FIFO.
- Reports per-frame events to the IRQ logic: rx_done, uart_parity_err, uart_bad_frame, overrun.
- Drives STATS.rx_status.
- Frame format is configured by CTRL fields supplied by the register block.

---
 rtl/uart_rx_core.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// UART receive engine: oversampled majority-vote deserialiser.
// Good frames go to the upstream FIFO; errors are reported as pulses.
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  rx_i,
  input  logic [DIV_WIDTH-1:0]  baud_div_i,
  input  logic                  parity_en_i,
  input  logic                  parity_odd_i,
  input  logic                  stop2_i,
  input  logic                  ufifo_full_i,
  output logic                  ufifo_push_o,
  output logic [DATA_WIDTH-1:0] ufifo_data_o,
  output logic                  rx_done_o,
  output logic                  parity_err_o,
  output logic                  bad_frame_o,
  output logic                  overrun_o,
  output logic                  rx_busy_o
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_WIDTH + 1);

  localparam logic [OSW-1:0] OS_S0   = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_S1   = OSW'(OVERSAMPLE / 2);
  localparam logic [OSW-1:0] OS_DEC  = OSW'(OVERSAMPLE / 2 + 1);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_FINISH,
    S_BRK
  } state_e;

  state_e                state_q, state_d;
  logic                  rx_meta_q, rx_meta_d;
  logic                  rx_s_q, rx_s_d;
  logic                  rx_prev_q, rx_prev_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic [OSW-1:0]        os_cnt_q, os_cnt_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]            smp_q, smp_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  perr_q, perr_d;
  logic                  par_en_q, par_en_d;
  logic                  par_odd_q, par_odd_d;
  logic                  stop2_q, stop2_d;
  logic                  hi_q, hi_d;
  logic                  push_q, push_d;
  logic                  done_q, done_d;
  logic                  perr_pls_q, perr_pls_d;
  logic                  bad_q, bad_d;
  logic                  ovr_q, ovr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic start_edge;
  logic tick;
  logic dec;
  logic eob;
  logic maj;

  // Synchroniser, tick generation, sampling and frame FSM next state.
  always_comb begin
    state_d    = state_q;
    rx_meta_d  = rx_i;
    rx_s_d     = rx_meta_q;
    rx_prev_d  = rx_s_q;
    div_d      = div_q;
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    smp_d      = smp_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;
    hi_d       = hi_q;
    push_d     = 1'b0;
    done_d     = 1'b0;
    perr_pls_d = 1'b0;
    bad_d      = 1'b0;
    ovr_d      = 1'b0;
    data_d     = data_q;

    start_edge = (state_q == S_IDLE) && rx_prev_q && !rx_s_q;
    tick       = (div_cnt_q == div_q - DIV_WIDTH'(1));
    div_cnt_d  = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);

    if (tick) begin
      os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OSW'(1);
    end
    if (tick && os_cnt_q == OS_S0) begin
      smp_d[0] = rx_s_q;
    end
    if (tick && os_cnt_q == OS_S1) begin
      smp_d[1] = rx_s_q;
    end

    maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q)
        | (smp_q[1] & rx_s_q);
    dec = tick && (os_cnt_q == OS_DEC);
    eob = tick && (os_cnt_q == OS_LAST);

    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d   = S_START;
          div_d     = (baud_div_i == '0) ? DIV_WIDTH'(1) : baud_div_i;
          div_cnt_d = '0;
          os_cnt_d  = '0;
          bit_cnt_d = '0;
          perr_d    = 1'b0;
          par_en_d  = parity_en_i;
          par_odd_d = parity_odd_i;
          stop2_d   = stop2_i;
        end
      end
      S_START: begin
        if (dec && maj) begin
          state_d = S_IDLE;
        end else if (eob) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (dec) begin
          shreg_d = {maj, shreg_q[DATA_WIDTH-1:1]};
        end
        if (eob) begin
          if (bit_cnt_q == BC_LAST) begin
            state_d = par_en_q ? S_PARITY : S_STOP1;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      S_PARITY: begin
        if (dec) begin
          perr_d = maj ^ (^shreg_q) ^ par_odd_q;
        end
        if (eob) begin
          state_d = S_STOP1;
        end
      end
      S_STOP1, S_STOP2: begin
        if (dec) begin
          if (!maj) begin
            bad_d   = 1'b1;
            hi_d    = 1'b0;
            state_d = S_BRK;
          end else if (state_q == S_STOP1 && stop2_q) begin
            state_d = S_STOP2;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        if (perr_q) begin
          perr_pls_d = 1'b1;
        end else if (ufifo_full_i) begin
          ovr_d = 1'b1;
        end else begin
          push_d = 1'b1;
          done_d = 1'b1;
          data_d = shreg_q;
        end
        state_d = S_IDLE;
      end
      S_BRK: begin
        if (!rx_s_q) begin
          hi_d = 1'b0;
        end else if (tick) begin
          if (hi_q) begin
            state_d = S_IDLE;
          end else begin
            hi_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; line synchroniser presets to idle-high.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      div_q      <= DIV_WIDTH'(1);
      div_cnt_q  <= '0;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      smp_q      <= 2'b11;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      hi_q       <= 1'b0;
      push_q     <= 1'b0;
      done_q     <= 1'b0;
      perr_pls_q <= 1'b0;
      bad_q      <= 1'b0;
      ovr_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      rx_prev_q  <= rx_prev_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      smp_q      <= smp_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      stop2_q    <= stop2_d;
      hi_q       <= hi_d;
      push_q     <= push_d;
      done_q     <= done_d;
      perr_pls_q <= perr_pls_d;
      bad_q      <= bad_d;
      ovr_q      <= ovr_d;
      data_q     <= data_d;
    end
  end

  assign ufifo_push_o = push_q;
  assign ufifo_data_o = data_q;
  assign rx_done_o    = done_q;
  assign parity_err_o = perr_pls_q;
  assign bad_frame_o  = bad_q;
  assign overrun_o    = ovr_q;
  assign rx_busy_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: clean frames, parity, framing,
// glitch, overrun, back-to-back and mid-frame reset.
module tb_uart_rx_core;

  localparam int BIT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] div = 16'd4;
  logic        pen = 1'b0;
  logic        podd = 1'b0;
  logic        st2 = 1'b0;
  logic        full = 1'b0;
  logic        push;
  logic [7:0]  data;
  logic        done;
  logic        perr;
  logic        bad;
  logic        ovr;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;
  int c_push, c_done, c_perr, c_bad, c_ovr;
  int c_multi = 0;
  logic [7:0] rxq[$];
  logic busy_mid;

  uart_rx_core dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .rx_i         (rx),
    .baud_div_i   (div),
    .parity_en_i  (pen),
    .parity_odd_i (podd),
    .stop2_i      (st2),
    .ufifo_full_i (full),
    .ufifo_push_o (push),
    .ufifo_data_o (data),
    .rx_done_o    (done),
    .parity_err_o (perr),
    .bad_frame_o  (bad),
    .overrun_o    (ovr),
    .rx_busy_o    (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (push) begin
        c_push++;
        rxq.push_back(data);
      end
      if (done) c_done++;
      if (perr) c_perr++;
      if (bad)  c_bad++;
      if (ovr)  c_ovr++;
      if ($countones({push, perr, bad, ovr}) > 1) c_multi++;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    c_push = 0;
    c_done = 0;
    c_perr = 0;
    c_bad  = 0;
    c_ovr  = 0;
    rxq.delete();
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic has_p,
                      input logic pbit, input int nstop,
                      input logic sval);
    send_bit(1'b0);
    busy_mid = busy;
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (has_p) send_bit(pbit);
    for (int i = 0; i < nstop; i++) send_bit(sval);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pop(output logic [7:0] v);
    if (rxq.size() > 0) v = rxq.pop_front();
    else v = 8'hxx;
  endtask

  initial begin
    logic [7:0] v;
    clr();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_push", push, 0);
    check("rst_data", data, 0);
    check("rst_pulses", {done, perr, bad, ovr}, 0);
    rst_n = 1'b1;
    idle(10);

    clr();
    send(8'hA5, 1'b0, 1'b0, 1, 1'b1);
    idle(20);
    check("a5_busy_mid", busy_mid, 1);
    check("a5_push", c_push, 1);
    check("a5_done", c_done, 1);
    pop(v);
    check("a5_data", v, 8'hA5);
    check("a5_err", c_perr + c_bad + c_ovr, 0);
    check("a5_busy_end", busy, 0);

    pen = 1'b1;
    podd = 1'b0;
    clr();
    send(8'h3C, 1'b1, 1'b1, 1, 1'b1);
    idle(20);
    check("par_err", c_perr, 1);
    check("par_nopush", c_push, 0);
    clr();
    send(8'h3C, 1'b1, 1'b0, 1, 1'b1);
    idle(20);
    check("par_ok_push", c_push, 1);
    pop(v);
    check("par_ok_data", v, 8'h3C);
    check("par_ok_err", c_perr, 0);
    pen = 1'b0;

    clr();
    send(8'h55, 1'b0, 1'b0, 0, 1'b1);
    rx = 1'b0;
    idle(200);
    check("brk_bad", c_bad, 1);
    check("brk_busy", busy, 1);
    check("brk_nopush", c_push + c_perr + c_ovr, 0);
    rx = 1'b1;
    idle(30);
    check("brk_release", busy, 0);
    send(8'h12, 1'b0, 1'b0, 1, 1'b1);
    idle(20);
    check("brk_next_push", c_push, 1);
    pop(v);
    check("brk_next_data", v, 8'h12);

    clr();
    rx = 1'b0;
    idle(10);
    check("gl_busy", busy, 1);
    repeat (10) @(posedge clk);
    rx = 1'b1;
    idle(100);
    check("gl_idle", busy, 0);
    check("gl_pulses", c_push + c_done + c_perr + c_bad + c_ovr, 0);

    clr();
    full = 1'b1;
    send(8'hFF, 1'b0, 1'b0, 1, 1'b1);
    idle(20);
    full = 1'b0;
    check("ovr_pulse", c_ovr, 1);
    check("ovr_nopush", c_push + c_done, 0);
    clr();
    st2 = 1'b1;
    send(8'h01, 1'b0, 1'b0, 2, 1'b1);
    send(8'h80, 1'b0, 1'b0, 2, 1'b1);
    idle(20);
    st2 = 1'b0;
    check("b2b_push", c_push, 2);
    pop(v);
    check("b2b_data0", v, 8'h01);
    pop(v);
    check("b2b_data1", v, 8'h80);

    clr();
    rx = 1'b0;
    repeat (BIT) @(posedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    rx = 1'b0;
    repeat (BIT / 2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mr_busy", busy, 0);
    check("mr_data", data, 0);
    check("mr_outs", {push, done, perr, bad, ovr}, 0);
    rx = 1'b1;
    idle(5);
    rst_n = 1'b1;
    idle(100);
    check("mr_quiet", c_push + c_done + c_perr + c_bad + c_ovr, 0);
    send(8'h7E, 1'b0, 1'b0, 1, 1'b1);
    idle(20);
    check("mr_push", c_push, 1);
    pop(v);
    check("mr_data7e", v, 8'h7E);
    check("mr_err", c_perr + c_bad + c_ovr, 0);

    check("exclusive", c_multi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
